ram512_arbiter: RTL and testbench
=================================

Name: ram512_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer in front of one RAM512 (16-bit x 512 words, combinational read, write on clock edge when load=1).
- Each requester uses a valid/ready request channel and receives a one-cycle response pulse.
- Sits between CPU-side and DMA/loader-side masters and the shared RAM512 instance; serializes all accesses.

Parameters:
- DATA_W, 16, data width; must match RAM512.
- ADDR_W, 9, word address width; 512 words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A request valid.
- a_write  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  word address.
- a_wdata  in  DATA_W  write data.
- a_ready  out  1  request accepted this cycle (handshake = a_valid & a_ready).
- a_rsp_valid  out  1  one-cycle response pulse.
- a_rdata  out  DATA_W  read data (write data echoed on writes); valid when a_rsp_valid=1.
- b_valid, b_write, b_addr, b_wdata, b_ready, b_rsp_valid, b_rdata: same as A, for requester B.
- ram_in  out  DATA_W  to RAM512 in.
- ram_address  out  ADDR_W  to RAM512 address.
- ram_load  out  1  to RAM512 load.
- ram_out  in  DATA_W  from RAM512 out.
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- FSM states are IDLE, ACCESS and RESP; the state register resets to IDLE. Every transaction takes exactly 3 cycles, so peak throughput is 1 access per 3 cycles.
- IDLE:
  - If any valid is high, the arbiter picks a winner and asserts that requester's ready combinationally in the same cycle.
  - On the edge, latch write/addr/wdata and the grant id, then move to ACCESS.
  - No valid: stay in IDLE.
- ACCESS:
  - ram_address = latched addr, ram_in = latched wdata, ram_load = latched write.
  - On the edge, RAM performs the write; the read-data register captures ram_out on reads and wdata on writes.
  - Move to RESP.
- RESP:
  - Granted requester's rsp_valid = 1 for exactly one cycle and its rdata = captured register.
  - No ready is asserted in RESP.
  - Move to IDLE.
- ram_load is 1 only in ACCESS with a latched write, and is decoded combinationally from state. ram_address and ram_in always reflect the latched registers.
- Arbitration:
  - last_grant register resets to B, so A wins the first tie.
  - Both valid: grant the requester not granted last. Single valid: grant it.
  - last_grant updates only on a handshake.
- Ready rules:
  - At most one ready is high per cycle.
  - Ready is never high outside IDLE, and is forced 0 while rst_n=0.
- Requester may drop valid before ready without effect. Responses have no backpressure; requesters must accept them.
- rdata holds its last value between responses; rsp_valid is low otherwise.
- Reset values (asynchronous, any state): all ready/rsp_valid = 0, ram_load = 0, ram_address = 0, ram_in = 0, a_rdata = b_rdata = 0, busy = 0.
- Reset mid-ACCESS: ram_load drops immediately. The write is aborted unless the edge already occurred. No response is issued.
- Address wrap: no arithmetic is performed on addresses; full ADDR_W passes through, so 511 is valid.

Optional Feature:
- Macro RAM512_ARB_STATS_EN.
- Defined:
  - Adds outputs a_count and b_count, 16 bits each.
  - Each increments by 1 on its requester's handshake, wraps 65535 -> 0, and resets to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header ram512_arb_defs.vh holds:
  - State encodings: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Grant ids: GNT_A=1'b0, GNT_B=1'b1.
  - DATA_W and ADDR_W defaults.
- One sub-module, rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, enable.
  - Outputs: gnt[1:0] one-hot and gnt_id.
  - Purely combinational.
- last_grant state lives in ram512_arbiter.

Test Plan:
- A writes 16'hFFFF to addr 1, then A reads addr 1 -> ram_load high for exactly the ACCESS cycle of the write; the read gives a_rsp_valid 2 cycles after its handshake with a_rdata=16'hFFFF.
- A and B both valid from reset (A reads 5, B reads 500), held valid -> grants alternate A, B, A, B; handshakes 3 cycles apart; never both ready.
- B writes 16'h0F0F to 511, then A reads 511 -> a_rdata=16'h0F0F; no address truncation.
- Assert rst_n=0 during ACCESS of a write of 16'h1234 to addr 100 -> ram_load falls immediately, no rsp_valid, all outputs 0; a subsequent read of 100 returns the prior contents.
- a_valid pulses 1 cycle while FSM is in RESP (not IDLE), then drops -> no handshake and no A transaction.
- With RAM512_ARB_STATS_EN, 3 A and 2 B transactions -> a_count=3, b_count=2; reset -> both 0.

Source files
------------

// File: rtl/ram512_arbiter_pkg.sv
// Shared definitions for the RAM512 arbiter slice.
//   state_t      : sequencer states (IDLE=0, ACCESS=1, RESP=2)
//   GNT_A/GNT_B  : grant ids used for last_grant and the latched winner
//   DATA_W_DEF / ADDR_W_DEF : default data and word-address widths of RAM512
package ram512_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 9;

endpackage

// File: rtl/ram512_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0]   in  : request lines (bit 0 = A, bit 1 = B)
//   last_grant in  : id of the requester granted on the previous handshake
//   enable     in  : when low no grant is issued
//   gnt[1:0]   out : one-hot grant (all zero when disabled or no request)
//   gnt_id     out : id of the winner (only meaningful when gnt != 0)
module rr_arb2
    import ram512_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = GNT_A;
        gnt    = 2'b00;
        case (req)
            2'b01:   gnt_id = GNT_A;
            2'b10:   gnt_id = GNT_B;
            // Contention: the side that did not win last time goes now.
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = GNT_A;
        endcase
        if (enable && (req != 2'b00)) begin
            gnt = (gnt_id == GNT_B) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ram512_arbiter.sv
// ram512_arbiter: round-robin arbiter and access sequencer for one RAM512.
// Each transaction is IDLE (handshake) -> ACCESS (RAM drive) -> RESP (pulse).
//
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   a_valid/a_write/a_addr/a_wdata   : requester A request channel (in)
//   a_ready                          : A request accepted this cycle
//   a_rsp_valid/a_rdata              : A one-cycle response, held read data
//   b_*                              : same set for requester B
//   ram_in/ram_address/ram_load      : drive RAM512
//   ram_out                          : RAM512 combinational read data
//   busy                             : high in ACCESS or RESP
//   a_count/b_count                  : handshake counters, only present when
//                                      RAM512_ARB_STATS_EN is defined
//
// state  | meaning
// IDLE   | arbitrate; winner's ready high; latch request on handshake
// ACCESS | RAM driven from latched request; write/read data captured
// RESP   | winner's rsp_valid pulses with captured data
module ram512_arbiter
    import ram512_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rdata,
`ifdef RAM512_ARB_STATS_EN
    output logic [15:0]       a_count,
    output logic [15:0]       b_count,
`endif
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              lat_id_q;
    logic              lat_write_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    logic [1:0]        gnt;
    logic              gnt_id;
    logic              arb_en;
    logic              hs;

    // Gating with rst_n keeps ready low while reset is held, even though the
    // state register already reads IDLE.
    assign arb_en = (state_q == IDLE) && rst_n;

    rr_arb2 u_rr_arb2 (
        .req        ({b_valid, a_valid}),
        .last_grant (last_grant_q),
        .enable     (arb_en),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    // gnt is already qualified by valid, so any grant is a handshake.
    assign hs = |gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        ram_load    = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                a_ready = gnt[0];
                b_ready = gnt[1];
                if (hs) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busy     = 1'b1;
                ram_load = lat_write_q;
                state_d  = RESP;
            end
            RESP: begin
                busy        = 1'b1;
                a_rsp_valid = (lat_id_q == GNT_A);
                b_rsp_valid = (lat_id_q == GNT_B);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_B;
            lat_id_q     <= GNT_A;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
        end else if (hs) begin
            last_grant_q <= gnt_id;
            lat_id_q     <= gnt_id;
            if (gnt_id == GNT_B) begin
                lat_write_q <= b_write;
                lat_addr_q  <= b_addr;
                lat_wdata_q <= b_wdata;
            end else begin
                lat_write_q <= a_write;
                lat_addr_q  <= a_addr;
                lat_wdata_q <= a_wdata;
            end
        end
    end

    // Per-requester data registers: loaded at the end of ACCESS so the value
    // is present during RESP and held until that requester's next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            if (lat_id_q == GNT_B) begin
                b_rdata_q <= lat_write_q ? lat_wdata_q : ram_out;
            end else begin
                a_rdata_q <= lat_write_q ? lat_wdata_q : ram_out;
            end
        end
    end

    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign ram_address = lat_addr_q;
    assign ram_in      = lat_wdata_q;

`ifdef RAM512_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= 16'd0;
            b_count <= 16'd0;
        end else begin
            if (gnt[0]) a_count <= a_count + 16'd1;
            if (gnt[1]) b_count <= b_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram512_arbiter.sv
// Directed self-checking bench for ram512_arbiter with a behavioural RAM512.
module tb_ram512_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, a_write, a_ready, a_rsp_valid;
    logic [8:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_valid, b_write, b_ready, b_rsp_valid;
    logic [8:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [15:0] ram_in, ram_out;
    logic [8:0]  ram_address;
    logic        ram_load;
    logic        busy;
`ifdef RAM512_ARB_STATS_EN
    logic [15:0] a_count, b_count;
`endif

    int checks = 0;
    int errors = 0;

    ram512_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_write     (a_write),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_ready     (a_ready),
        .a_rsp_valid (a_rsp_valid),
        .a_rdata     (a_rdata),
        .b_valid     (b_valid),
        .b_write     (b_write),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_ready     (b_ready),
        .b_rsp_valid (b_rsp_valid),
        .b_rdata     (b_rdata),
`ifdef RAM512_ARB_STATS_EN
        .a_count     (a_count),
        .b_count     (b_count),
`endif
        .ram_in      (ram_in),
        .ram_address (ram_address),
        .ram_load    (ram_load),
        .ram_out     (ram_out),
        .busy        (busy)
    );

    // Behavioural RAM512: combinational read, write on rising edge.
    logic [15:0] mem [0:511];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete transaction on one port; checks every phase.
    task automatic txn(input string tag, input bit is_b, input bit wr,
                       input logic [8:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd);
        int n;
        logic rdy, other_rdy, rsp;
        logic [15:0] rd;
        @(negedge clk);
        if (is_b) begin
            b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd;
        end
        #1;
        n = 0;
        rdy = is_b ? b_ready : a_ready;
        while (!rdy && n < 10) begin
            @(negedge clk); #1;
            n++;
            rdy = is_b ? b_ready : a_ready;
        end
        other_rdy = is_b ? a_ready : b_ready;
        chk({tag, "_ready"}, rdy, 1);
        chk({tag, "_other_ready"}, other_rdy, 0);
        chk({tag, "_load_idle"}, ram_load, 0);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        chk({tag, "_load_access"}, ram_load, wr);
        chk({tag, "_addr_access"}, ram_address, addr);
        chk({tag, "_busy_access"}, busy, 1);
        @(negedge clk); #1;
        rsp = is_b ? b_rsp_valid : a_rsp_valid;
        rd  = is_b ? b_rdata : a_rdata;
        chk({tag, "_rsp"}, rsp, 1);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_load_resp"}, ram_load, 0);
        @(negedge clk); #1;
        rsp = is_b ? b_rsp_valid : a_rsp_valid;
        chk({tag, "_rsp_done"}, rsp, 0);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b1; a_write = 1'b0; a_addr = 9'd0; a_wdata = 16'h0;
        b_valid = 1'b1; b_write = 1'b0; b_addr = 9'd0; b_wdata = 16'h0;
        #2;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load", ram_load, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_ram_in", ram_in, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        do_reset();

        // Write then read back at address 1.
        txn("a_wr1", 0, 1, 9'd1, 16'hFFFF, 16'hFFFF);
        txn("a_rd1", 0, 0, 9'd1, 16'h0000, 16'hFFFF);

        // Full-width address 511.
        txn("b_wr511", 1, 1, 9'd511, 16'h0F0F, 16'h0F0F);
        txn("a_rd511", 0, 0, 9'd511, 16'h0000, 16'h0F0F);

        // Reset in the middle of a write's ACCESS cycle.
        txn("a_wr100", 0, 1, 9'd100, 16'hBEEF, 16'hBEEF);
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 9'd100; a_wdata = 16'h1234;
        #1;
        chk("mid_ready", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        chk("mid_load_before", ram_load, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_load_after", ram_load, 0);
        chk("mid_busy", busy, 0);
        chk("mid_addr", ram_address, 0);
        chk("mid_ram_in", ram_in, 0);
        chk("mid_a_rdata", a_rdata, 0);
        chk("mid_b_rdata", b_rdata, 0);
        a_valid = 1'b1;
        #1;
        chk("mid_ready_in_rst", a_ready, 0);
        a_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("mid_no_rsp", a_rsp_valid, 0);
            chk("mid_idle", busy, 0);
        end
        txn("a_rd100", 0, 0, 9'd100, 16'h0000, 16'hBEEF);

        // A pulses valid only during B's RESP cycle.
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b0; b_addr = 9'd511;
        #1;
        chk("pulse_b_ready", b_ready, 1);
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 9'd7; a_wdata = 16'h7777;
        #1;
        chk("pulse_a_ready_resp", a_ready, 0);
        chk("pulse_b_rsp", b_rsp_valid, 1);
        chk("pulse_b_rdata", b_rdata, 16'h0F0F);
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pulse_busy", busy, 0);
            chk("pulse_load", ram_load, 0);
            @(negedge clk);
        end
        txn("a_rd7", 0, 0, 9'd7, 16'h0000, 16'h0000);

        // Contention from reset: alternating grants every 3 cycles.
        txn("a_wr5", 0, 1, 9'd5, 16'h1111, 16'h1111);
        txn("b_wr500", 1, 1, 9'd500, 16'h2222, 16'h2222);
        @(negedge clk);
        do_reset();
        a_valid = 1'b1; a_write = 1'b0; a_addr = 9'd5;
        b_valid = 1'b1; b_write = 1'b0; b_addr = 9'd500;
        for (int k = 0; k < 12; k++) begin
            bit turn_b;
            if (k > 0) @(negedge clk);
            #1;
            turn_b = ((k / 3) % 2) == 1;
            chk($sformatf("rr_a_ready_%0d", k), a_ready, (k % 3 == 0) && !turn_b);
            chk($sformatf("rr_b_ready_%0d", k), b_ready, (k % 3 == 0) && turn_b);
            chk($sformatf("rr_one_hot_%0d", k), a_ready & b_ready, 0);
            if (k % 3 == 2) begin
                chk($sformatf("rr_a_rsp_%0d", k), a_rsp_valid, !turn_b);
                chk($sformatf("rr_b_rsp_%0d", k), b_rsp_valid, turn_b);
                if (turn_b) chk($sformatf("rr_b_rdata_%0d", k), b_rdata, 16'h2222);
                else        chk($sformatf("rr_a_rdata_%0d", k), a_rdata, 16'h1111);
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;

`ifdef RAM512_ARB_STATS_EN
        @(negedge clk);
        do_reset();
        #1;
        chk("cnt_a_rst0", a_count, 0);
        txn("s_a0", 0, 0, 9'd5, 16'h0, 16'h1111);
        txn("s_b0", 1, 0, 9'd500, 16'h0, 16'h2222);
        txn("s_a1", 0, 0, 9'd5, 16'h0, 16'h1111);
        txn("s_a2", 0, 1, 9'd9, 16'h0009, 16'h0009);
        txn("s_b1", 1, 0, 9'd9, 16'h0, 16'h0009);
        chk("cnt_a", a_count, 3);
        chk("cnt_b", b_count, 2);
        rst_n = 1'b0;
        #1;
        chk("cnt_a_rst", a_count, 0);
        chk("cnt_b_rst", b_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
